// File: rtl/seq_lock_pkg.sv
// -----------------------------------------------------------------------------
// seq_lock_pkg
// Shared definitions for the combination-lock controller.
//   - state_t     : FSM state encoding (IDLE/ENTRY/OPEN/FAIL/LOCK). The
//                   values are visible on the state output.
//   - SYM_A/B/C   : 2-bit symbol codes used inside the packed CODE parameter.
//   - code_sym()  : extracts symbol i from a packed code.
//   - tmr_width() : width of the shared down-stream timer.
// -----------------------------------------------------------------------------
package seq_lock_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      OPEN  = 3'd2,
      FAIL  = 3'd3,
      LOCK  = 3'd4
   } state_t;

   localparam logic [1:0] SYM_A = 2'd0;
   localparam logic [1:0] SYM_B = 2'd1;
   localparam logic [1:0] SYM_C = 2'd2;

   // Longest supported code; packed codes are zero-extended to this size.
   localparam int CODE_MAX_LEN = 8;

   // Symbol i lives at code[2i+1:2i].
   function automatic logic [1:0] code_sym(input logic [2*CODE_MAX_LEN-1:0] code,
                                           input logic [2:0]                i);
      return code[{i, 1'b0} +: 2];
   endfunction

   // One timer serves the timeout, open and lock periods, so it is sized for
   // the longest of the three.
   function automatic int tmr_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/seq_lock_if.sv
// -----------------------------------------------------------------------------
// seq_lock_if
// Button inputs and status outputs of the combination-lock controller.
//   A, B, C   : button levels (driven by the master side)
//   state     : current FSM state encoding
//   unlock    : high while the lock is open
//   err       : one-cycle pulse on a failed attempt
//   lockout   : high while the lockout period runs
//   fail_cnt  : consecutive failure count
// Modports: master = button/LED side, slave = the controller.
// -----------------------------------------------------------------------------
interface seq_lock_if;
   logic       A;
   logic       B;
   logic       C;
   logic [2:0] state;
   logic       unlock;
   logic       err;
   logic       lockout;
   logic [2:0] fail_cnt;

   modport master (
      output A, B, C,
      input  state, unlock, err, lockout, fail_cnt
   );

   modport slave (
      input  A, B, C,
      output state, unlock, err, lockout, fail_cnt
   );
endinterface

// File: rtl/btn_edge_detect.sv
// -----------------------------------------------------------------------------
// btn_edge_detect
// Rising-edge detector for the three button levels.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   btn  : button levels {C, B, A}
//   ev   : one-cycle rising-edge strobes {C, B, A}
// Optional macro SEQ_LOCK_SYNC_EN: when defined each button first passes a
// 2-flop synchronizer (reset to 0); otherwise buttons must already be
// synchronous to clk and feed the detector directly.
// The edge history resets to 0, so a button held across reset release fires
// on the first clock after release.
// -----------------------------------------------------------------------------
module btn_edge_detect (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] btn,
   output logic [2:0] ev
);

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         logic btn_s;
         logic prev_reg;

`ifdef SEQ_LOCK_SYNC_EN
         logic sync1_reg;
         logic sync2_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
            end else begin
               sync1_reg <= btn[gi];
               sync2_reg <= sync1_reg;
            end
         end

         assign btn_s = sync2_reg;
`else
         assign btn_s = btn[gi];
`endif

         // History updates every cycle regardless of FSM state, so a button
         // held through OPEN/LOCK does not produce an edge afterwards.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               prev_reg <= 1'b0;
            end else begin
               prev_reg <= btn_s;
            end
         end

         assign ev[gi] = btn_s & ~prev_reg;
      end
   endgenerate

endmodule

// File: rtl/seq_lock_ctrl.sv
// -----------------------------------------------------------------------------
// seq_lock_ctrl
// Combination-lock controller. Button edges are compared against a packed
// code one symbol at a time; a gap longer than TIMEOUT_CYC, a wrong symbol or
// a multi-press fails the attempt. MAX_FAIL consecutive failures trigger a
// LOCK_CYC lockout; a correct code opens the lock for OPEN_CYC cycles.
//
// Parameters:
//   CODE_LEN    : symbols in the code (2..8)
//   CODE        : packed code, symbol i at CODE[2i+1:2i] (00=A 01=B 10=C)
//   TIMEOUT_CYC : idle cycles allowed between symbols
//   MAX_FAIL    : consecutive failures that trigger a lockout (1..7)
//   OPEN_CYC    : cycles the unlock output is held
//   LOCK_CYC    : cycles the lockout lasts
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : seq_lock_if.slave (buttons in, state/unlock/err/lockout/fail_cnt out)
// Optional macro SEQ_LOCK_SYNC_EN (in btn_edge_detect) adds input
// synchronizers; edge-to-state latency then grows from 1 to 3 cycles.
// All outputs are registered and change together with the state register.
// -----------------------------------------------------------------------------
module seq_lock_ctrl
   import seq_lock_pkg::*;
#(
   parameter int                    CODE_LEN    = 4,
   parameter logic [2*CODE_LEN-1:0] CODE        = 8'h84,
   parameter int                    TIMEOUT_CYC = 16,
   parameter int                    MAX_FAIL    = 3,
   parameter int                    OPEN_CYC    = 8,
   parameter int                    LOCK_CYC    = 32
) (
   input  logic      clk,
   input  logic      rst,
   seq_lock_if.slave bus
);

   localparam int TMR_W = tmr_width(TIMEOUT_CYC, OPEN_CYC, LOCK_CYC);

   localparam logic [TMR_W-1:0]          TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0]          OPEN_LAST    = TMR_W'(OPEN_CYC - 1);
   localparam logic [TMR_W-1:0]          LOCK_LAST    = TMR_W'(LOCK_CYC - 1);
   localparam logic [2:0]                IDX_LAST     = 3'(CODE_LEN - 1);
   localparam logic [3:0]                FAIL_LIMIT   = 4'(MAX_FAIL);
   localparam logic [2:0]                FAIL_SAT     = 3'(MAX_FAIL);
   localparam logic [2*CODE_MAX_LEN-1:0] CODE_EXT     = (2*CODE_MAX_LEN)'(CODE);

   // ---------------------------------------------------------------------
   // Edge detection and symbol decode
   // ---------------------------------------------------------------------
   logic [2:0] ev;
   logic [1:0] nev;
   logic [1:0] ev_sym;
   logic [1:0] exp_sym;
   logic       any_ev;
   logic       hit;

   btn_edge_detect u_edge (
      .clk (clk),
      .rst (rst),
      .btn ({bus.C, bus.B, bus.A}),
      .ev  (ev)
   );

   assign nev    = {1'b0, ev[0]} + {1'b0, ev[1]} + {1'b0, ev[2]};
   assign any_ev = (nev != 2'd0);

   // Only meaningful when exactly one event is present.
   always_comb begin
      ev_sym = SYM_A;
      if (ev[1]) ev_sym = SYM_B;
      if (ev[2]) ev_sym = SYM_C;
   end

   // idx_reg is held at 0 outside ENTRY, so in IDLE this selects CODE[0].
   logic [2:0] idx_reg;

   assign exp_sym = code_sym(CODE_EXT, idx_reg);

   // A multi-press (nev >= 2) is never a hit.
   assign hit = (nev == 2'd1) && (ev_sym == exp_sym);

   // ---------------------------------------------------------------------
   // FSM, shared timer and failure counter
   // ---------------------------------------------------------------------
   state_t           state_reg;
   logic [TMR_W-1:0] timer_reg;
   logic [2:0]       fail_cnt_reg;
   logic             unlock_reg;
   logic             err_reg;
   logic             lockout_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         idx_reg      <= '0;
         timer_reg    <= '0;
         fail_cnt_reg <= '0;
         unlock_reg   <= 1'b0;
         err_reg      <= 1'b0;
         lockout_reg  <= 1'b0;
      end else begin
         // err marks the single FAIL cycle; it is re-armed only on entry.
         err_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (any_ev) begin
                  timer_reg <= '0;
                  if (hit) begin
                     state_reg <= ENTRY;
                     idx_reg   <= 3'd1;
                  end else begin
                     state_reg <= FAIL;
                     err_reg   <= 1'b1;
                  end
               end
            end

            ENTRY: begin
               // A button edge outranks a timeout expiring on the same cycle.
               if (any_ev) begin
                  timer_reg <= '0;
                  if (!hit) begin
                     state_reg <= FAIL;
                     err_reg   <= 1'b1;
                     idx_reg   <= '0;
                  end else if (idx_reg == IDX_LAST) begin
                     state_reg    <= OPEN;
                     unlock_reg   <= 1'b1;
                     fail_cnt_reg <= '0;
                     idx_reg      <= '0;
                  end else begin
                     idx_reg <= idx_reg + 3'd1;
                  end
               end else if (timer_reg == TIMEOUT_LAST) begin
                  state_reg <= FAIL;
                  err_reg   <= 1'b1;
                  timer_reg <= '0;
                  idx_reg   <= '0;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end

            FAIL: begin
               timer_reg <= '0;
               if (({1'b0, fail_cnt_reg} + 4'd1) >= FAIL_LIMIT) begin
                  state_reg    <= LOCK;
                  lockout_reg  <= 1'b1;
                  fail_cnt_reg <= FAIL_SAT;
               end else begin
                  state_reg    <= IDLE;
                  fail_cnt_reg <= fail_cnt_reg + 3'd1;
               end
            end

            OPEN: begin
               // Button edges are ignored while open.
               if (timer_reg == OPEN_LAST) begin
                  state_reg  <= IDLE;
                  unlock_reg <= 1'b0;
                  timer_reg  <= '0;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end

            LOCK: begin
               // Button edges are ignored during the lockout.
               if (timer_reg == LOCK_LAST) begin
                  state_reg    <= IDLE;
                  lockout_reg  <= 1'b0;
                  fail_cnt_reg <= '0;
                  timer_reg    <= '0;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end

            default: begin
               // Encodings 5..7 fall back to a clean IDLE.
               state_reg   <= IDLE;
               idx_reg     <= '0;
               timer_reg   <= '0;
               unlock_reg  <= 1'b0;
               err_reg     <= 1'b0;
               lockout_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.state    = state_reg;
   assign bus.unlock   = unlock_reg;
   assign bus.err      = err_reg;
   assign bus.lockout  = lockout_reg;
   assign bus.fail_cnt = fail_cnt_reg;

endmodule

// File: doc/seq_lock_ctrl.md
Name: seq_lock_ctrl

Overview:
- Controller that sequences button events A/B/C into a programmable code-entry state machine (combination lock).
- Performs rising-edge detection on the three level inputs, compares each symbol against a parameterised code and enforces an inter-symbol timeout.
- Counts failed attempts and imposes a timed lockout after too many failures.
- Sits between the lab push-button inputs and the board LEDs; exposes its encoded state for display.

Parameters:
- CODE_LEN, 4, number of symbols in the code; legal range 2..8.
- CODE, 8'h84, packed code. Symbol i sits at CODE[2i+1:2i]; 00=A, 01=B, 10=C, 11 illegal. The default 8'h84 is the sequence A,B,A,C.
- TIMEOUT_CYC, 16, idle cycles allowed between symbols in ENTRY before the attempt fails.
- MAX_FAIL, 3, consecutive failures that trigger LOCK; legal range 1..7.
- OPEN_CYC, 8, cycles the unlock output is held.
- LOCK_CYC, 32, cycles the lockout lasts.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- A  in  1  button A level.
- B  in  1  button B level.
- C  in  1  button C level.
- state  out  3  current state encoding.
- unlock  out  1  high while in OPEN.
- err  out  1  high for the single FAIL cycle.
- lockout  out  1  high while in LOCK.
- fail_cnt  out  3  consecutive failure count.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-low. While rst=0:
  - state=IDLE (3'd0), unlock=0, err=0, lockout=0, fail_cnt=0.
  - Internal symbol index, timer and edge-history registers are cleared. Edge history is cleared to 0, so a button already held high when rst releases produces an edge on the first clock after release.
  - Reset mid-operation aborts any entry, lockout or open period immediately.
- Edge detection:
  - ev_X = X & ~X_prev, with X_prev registered every cycle.
  - nev = ev_A + ev_B + ev_C.
  - sym is the index of the single asserted event.
  - nev>=2 is a "multi-press" and always counts as a mismatch.
- Outputs are Moore, decoded from the state register. An edge sampled at clock k changes state at edge k, so the outputs are visible one cycle after the input rises.
- State encodings:
  - IDLE=0, ENTRY=1, OPEN=2, FAIL=3, LOCK=4.
  - Encodings 5..7 are illegal and recover to IDLE on the next clock.
- IDLE:
  - nev=0: stay.
  - Single edge with sym==CODE[0]: go to ENTRY, idx=1, timer=0.
  - Any other edge: go to FAIL.
- ENTRY:
  - nev=0: timer++. When timer reaches TIMEOUT_CYC-1 with no edge, go to FAIL.
  - Matching edge (sym==CODE[idx]): timer=0. If idx==CODE_LEN-1, go to OPEN; otherwise idx++.
  - Mismatch or multi-press: go to FAIL.
  - An edge on the same cycle the timeout expires takes priority over the timeout.
- FAIL (exactly 1 cycle):
  - Always go to IDLE, with one exception below. fail_cnt saturates at MAX_FAIL.
  - If fail_cnt+1==MAX_FAIL, go to LOCK instead.
- OPEN:
  - On entry, fail_cnt=0 and timer=0.
  - Edges are ignored.
  - After OPEN_CYC cycles, go to IDLE.
- LOCK:
  - Edges are ignored, but edge history still updates, so a button held through the lockout does not fire on exit.
  - After LOCK_CYC cycles, go to IDLE and set fail_cnt=0.
- Timer width is clog2 of the maximum of TIMEOUT_CYC, OPEN_CYC and LOCK_CYC. The timer is shared, since only one state counts at a time, and is cleared on every state change.

Optional Feature:
- Macro: SEQ_LOCK_SYNC_EN.
- When defined: A/B/C each pass through a 2-flop synchronizer, reset to 0, before edge detection. Edge-to-state latency becomes 3 cycles.
- When undefined: inputs feed edge detection directly, with 1-cycle latency as above. The inputs are then required to be synchronous to clk.

Decomposition:
- Package seq_lock_pkg contains:
  - state localparams IDLE/ENTRY/OPEN/FAIL/LOCK;
  - symbol constants SYM_A/SYM_B/SYM_C;
  - a function extracting symbol i from CODE.
- One sub-module, btn_edge_detect: 3-bit rising-edge detector, containing the optional synchronizer, with outputs ev[2:0].
- The FSM, timer and fail counter stay in seq_lock_ctrl.

Test Plan:
1. Correct code, default CODE=8'h84: pulse A, B, A, C, each high for 2 cycles with 2 cycles low between. Required response: state 0->1 on the A edge, then state=2 and unlock=1 for exactly 8 cycles, then state=0; fail_cnt stays 0.
2. Wrong symbol: A then C. Required response: state=3 and err=1 for 1 cycle, then state=0 and fail_cnt=1.
3. Timeout: press A, then no input for 16 cycles. Required response: state=3 on the 16th idle cycle, then IDLE and fail_cnt=1. Also press B on exactly the 16th cycle; required response: the attempt advances, idx=2, and no FAIL occurs.
4. Lockout: three consecutive wrong entries. Required response: the third FAIL goes to state=4 with lockout=1 for 32 cycles; button edges during LOCK cause no change; then state=0 and fail_cnt=0.
5. Multi-press: A and B rise on the same cycle in IDLE. Required response: FAIL. Then a correct entry clears fail_cnt to 0 on entry to OPEN.
6. Reset mid-operation: drop rst to 0 asynchronously in the middle of ENTRY, and again during LOCK. Required response: all outputs go to 0 immediately, without waiting for a clock edge; after rst is released, a full correct code opens normally.
